// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit-validity helper for the serial BCD adder.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_ADJ = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between a requester and the serial BCD add controller.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] sum;
  logic                cout;
  logic                err;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary add, then +6 correction when the raw sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] S,
  output logic       CO
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, A} + {1'b0, B} + {4'b0, CI};
    CO  = 1'b0;
    S   = raw[3:0];
    // Out-of-range digits still follow the same rule; only the controller flags them.
    if (raw > 5'(BCD_MAX)) begin
      CO = 1'b1;
      S  = raw[3:0] + 4'(BCD_ADJ);
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller: one digit pair per clock, LSD first,
// sharing a single bcd_digit_add with the carry chained through a register.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  state_t         state_reg, state_next;
  // Low digits hold the not-yet-consumed operand A; sum digits enter from the top.
  logic [W-1:0]   opa_acc_reg, opa_acc_next;
  logic [W-1:0]   opb_reg, opb_next;
  logic           carry_reg, carry_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           errf_reg, errf_next;
  logic [W-1:0]   sum_reg, sum_next;
  logic           cout_reg, cout_next;
  logic           err_reg, err_next;

  logic [3:0]     digit_s;
  logic           digit_co;
  logic [W-1:0]   opa_acc_shifted;
  logic [W-1:0]   opb_shifted;

  bcd_digit_add u_digit_add (
    .A  (opa_acc_reg[3:0]),
    .B  (opb_reg[3:0]),
    .CI (carry_reg),
    .S  (digit_s),
    .CO (digit_co)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_shift
      if (gi == DIGITS - 1) begin : g_top
        assign opa_acc_shifted[gi*DIGIT_W +: DIGIT_W] = digit_s;
        assign opb_shifted[gi*DIGIT_W +: DIGIT_W]     = '0;
      end else begin : g_mid
        assign opa_acc_shifted[gi*DIGIT_W +: DIGIT_W] = opa_acc_reg[(gi+1)*DIGIT_W +: DIGIT_W];
        assign opb_shifted[gi*DIGIT_W +: DIGIT_W]     = opb_reg[(gi+1)*DIGIT_W +: DIGIT_W];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      opa_acc_reg <= '0;
      opb_reg     <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      errf_reg    <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      opa_acc_reg <= opa_acc_next;
      opb_reg     <= opb_next;
      carry_reg   <= carry_next;
      cnt_reg     <= cnt_next;
      errf_reg    <= errf_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    opa_acc_next = opa_acc_reg;
    opb_next     = opb_reg;
    carry_next   = carry_reg;
    cnt_next     = cnt_reg;
    errf_next    = errf_reg;
    sum_next     = sum_reg;
    cout_next    = cout_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          state_next   = RUN;
          opa_acc_next = bus.a;
          opb_next     = bus.b;
          carry_next   = 1'b0;
          cnt_next     = '0;
          errf_next    = 1'b0;
        end
      end
      RUN: begin
        opa_acc_next = opa_acc_shifted;
        opb_next     = opb_shifted;
        carry_next   = digit_co;
        errf_next    = errf_reg | digit_invalid(opa_acc_reg[3:0])
                                | digit_invalid(opb_reg[3:0]);
        if (cnt_reg == LAST_CNT) begin
          state_next = DONE;
          sum_next   = opa_acc_shifted;
          cout_next  = digit_co;
          err_next   = errf_next;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (DIGITS=4): directed cases plus random ops
// checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, cout, sum}. Valid operands use plain decimal arithmetic;
  // operands with non-BCD digits fall back to the per-digit add/+6 rule.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    int xv, yv, tot, dx, dy, s, c;
    logic e;
    logic [15:0] r;
    e = 1'b0; xv = 0; yv = 0; r = '0; c = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dx = int'((x >> (4*i)) & 16'hF);
      dy = int'((y >> (4*i)) & 16'hF);
      if (dx > 9 || dy > 9) e = 1'b1;
      xv = xv * 10 + dx;
      yv = yv * 10 + dy;
    end
    if (!e) begin
      tot = xv + yv;
      c   = (tot >= 10000) ? 1 : 0;
      tot = tot % 10000;
      for (int i = 0; i < DIGITS; i++) begin
        r[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        s = int'((x >> (4*i)) & 16'hF) + int'((y >> (4*i)) & 16'hF) + c;
        if (s > 9) begin s = s + 6; c = 1; end else c = 0;
        r[4*i +: 4] = 4'(s % 16);
      end
    end
    return {e, 1'(c), r};
  endfunction

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, checking busy duration and result; returns in the DONE cycle.
  task automatic finish_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input int exp_busy);
    logic [17:0] r;
    int bc, got;
    r = ref_add(x, y);
    bc = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin got = 1; break; end
      if (bus.busy) bc++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    if (got == 1) begin
      chk({tag, "_busy_with_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_sum"}, 32'(bus.sum), 32'(r[15:0]));
      chk({tag, "_cout"}, 32'(bus.cout), 32'(r[16]));
      chk({tag, "_err"}, 32'(bus.err), 32'(r[17]));
    end
    $display("op %s a=%h b=%h sum=%h cout=%0d err=%0d busy_cycles=%0d", tag, x, y,
             bus.sum, bus.cout, bus.err, bc);
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.done) n++;
      @(negedge clk);
    end
    chk({tag, "_extra_done"}, 32'(n), 32'd0);
  endtask

  initial begin
    logic [15:0] x, y;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_sum",  32'(bus.sum),  32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    chk("reset_err",  32'(bus.err),  32'd0);
    @(negedge clk);

    launch(16'h1234, 16'h5678);
    finish_op("basic", 16'h1234, 16'h5678, 4);
    chk("basic_sum_const", 32'(bus.sum), 32'h6912);
    @(negedge clk);

    launch(16'h9999, 16'h0001);
    finish_op("ripple", 16'h9999, 16'h0001, 4);
    chk("ripple_cout_const", 32'(bus.cout), 32'd1);
    @(negedge clk);

    launch(16'h0005, 16'h0006);
    finish_op("b2b_first", 16'h0005, 16'h0006, 4);
    chk("b2b_first_const", 32'(bus.sum), 32'h0011);
    launch(16'h0009, 16'h0006);
    chk("b2b_no_idle_busy", 32'(bus.busy), 32'd1);
    finish_op("b2b_second", 16'h0009, 16'h0006, 4);
    chk("b2b_second_const", 32'(bus.sum), 32'h0015);
    @(negedge clk);

    launch(16'h00A0, 16'h0001);
    finish_op("invalid", 16'h00A0, 16'h0001, 4);
    chk("invalid_err_const", 32'(bus.err), 32'd1);
    @(negedge clk);
    launch(16'h0001, 16'h0001);
    finish_op("after_invalid", 16'h0001, 16'h0001, 4);
    chk("after_invalid_const", 32'(bus.sum), 32'h0002);
    @(negedge clk);

    launch(16'h4321, 16'h1111);
    bus.a     = 16'h9876;
    bus.b     = 16'h5555;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op("ignored_start", 16'h4321, 16'h1111, 3);
    @(negedge clk);
    expect_no_done("ignored_start", 8);

    launch(16'h2468, 16'h1357);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_sum",  32'(bus.sum),  32'd0);
    chk("midrst_cout", 32'(bus.cout), 32'd0);
    chk("midrst_err",  32'(bus.err),  32'd0);
    $display("op midrst sum=%h busy=%0d done=%0d", bus.sum, bus.busy, bus.done);
    expect_no_done("midrst", 6);
    launch(16'h0808, 16'h0202);
    finish_op("after_rst", 16'h0808, 16'h0202, 4);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) begin
        x = 16'($urandom);
        y = 16'($urandom);
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          x[4*d +: 4] = 4'($urandom_range(0, 9));
          y[4*d +: 4] = 4'($urandom_range(0, 9));
        end
      end
      launch(x, y);
      finish_op($sformatf("rand%0d", i), x, y, 4);
      if (i % 3 != 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
